// File: rtl/alu_rs_pkg.sv
// Shared widths, tag encoding and entry layout for the ALU reservation station.
// The snoop helper is used both for dispatch-cycle capture and for wakeup.
package alu_rs_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int NAME_W = 5;
  localparam int OP_W   = 6;

  localparam logic [TAG_W-1:0] TAG_FREE = '1;
  localparam logic             ENABLE   = 1'b1;
  localparam logic             DISABLE  = 1'b0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    logic              en;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    operand_t          src1;
    operand_t          src2;
    logic [TAG_W-1:0]  dst_tag;
    logic [NAME_W-1:0] dst_name;
  } entry_t;

  // A free operand never compares against a bus; ALU wins a double match.
  function automatic operand_t snoop(operand_t opnd, cdb_t alu, cdb_t ls);
    operand_t res;
    res = opnd;
    if (opnd.tag != TAG_FREE) begin
      if (alu.en && alu.tag == opnd.tag) begin
        res.tag  = TAG_FREE;
        res.data = alu.data;
      end else if (ls.en && ls.tag == opnd.tag) begin
        res.tag  = TAG_FREE;
        res.data = ls.data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_prio_pick.sv
// Lowest-index priority encoder: returns the index of the lowest set request
// bit and whether any bit was set.
module rs_prio_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; scanning high-to-low lets the
  // lowest set bit overwrite last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: captures dispatched operands, wakes them from the
// ALU/LS broadcast buses, and issues the lowest ready entry through a skid-free
// registered valid/ready port.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_tag_o,
  input  logic [DATA_W-1:0] disp_data_o,
  input  logic [TAG_W-1:0]  disp_tag_t,
  input  logic [DATA_W-1:0] disp_data_t,
  input  logic [TAG_W-1:0]  disp_dst_tag,
  input  logic [NAME_W-1:0] disp_dst_name,
  output logic              rs_full,
  input  logic              alu_cdb_en,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_data,
  input  logic              ls_cdb_en,
  input  logic [TAG_W-1:0]  ls_cdb_tag,
  input  logic [DATA_W-1:0] ls_cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_src1,
  output logic [DATA_W-1:0] iss_src2,
  output logic [TAG_W-1:0]  iss_dst_tag,
  output logic [NAME_W-1:0] iss_dst_name
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  entry_t             r_ent [ENTRIES];

  logic [ENTRIES-1:0] w_ready;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_free_found;
  logic               w_pick_found;
  logic               w_adv;
  logic               w_disp_we;
  cdb_t               w_alu_cdb;
  cdb_t               w_ls_cdb;
  entry_t             w_disp_ent;

  assign w_alu_cdb = '{en: alu_cdb_en, tag: alu_cdb_tag, data: alu_cdb_data};
  assign w_ls_cdb  = '{en: ls_cdb_en,  tag: ls_cdb_tag,  data: ls_cdb_data};

  assign rs_full   = &r_valid;
  assign w_disp_we = disp_valid && w_free_found;
  assign w_adv     = !iss_valid || iss_ready;

  // Readiness comes from registered tags only, so a wake at edge N is
  // selectable in the following cycle.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_ready[i] = r_valid[i] && (r_ent[i].src1.tag == TAG_FREE)
                              && (r_ent[i].src2.tag == TAG_FREE);
    end
  end

  always_comb begin
    w_disp_ent          = '0;
    w_disp_ent.op       = disp_op;
    w_disp_ent.src1     = snoop('{tag: disp_tag_o, data: disp_data_o}, w_alu_cdb, w_ls_cdb);
    w_disp_ent.src2     = snoop('{tag: disp_tag_t, data: disp_data_t}, w_alu_cdb, w_ls_cdb);
    w_disp_ent.dst_tag  = disp_dst_tag;
    w_disp_ent.dst_name = disp_dst_name;
  end

  rs_prio_pick #(.N(ENTRIES)) u_free_pick (
    .i_req   (~r_valid),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_prio_pick #(.N(ENTRIES)) u_ready_pick (
    .i_req   (w_ready),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // NOTE: entry payload is deliberately left out of reset; the valid bits
  // alone decide whether a slot means anything, which keeps this a plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_disp_we && (w_free_idx == IDX_W'(i))) begin
        r_ent[i] <= w_disp_ent;
      end else if (r_valid[i]) begin
        r_ent[i].src1 <= snoop(r_ent[i].src1, w_alu_cdb, w_ls_cdb);
        r_ent[i].src2 <= snoop(r_ent[i].src2, w_alu_cdb, w_ls_cdb);
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; the issue clear and the dispatch set never hit the same
  // slot because one is valid and the other free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      iss_valid    <= DISABLE;
      iss_op       <= '0;
      iss_src1     <= '0;
      iss_src2     <= '0;
      iss_dst_tag  <= '0;
      iss_dst_name <= '0;
    end else begin
      if (w_adv) begin
        if (w_pick_found) begin
          iss_valid            <= ENABLE;
          iss_op               <= r_ent[w_pick_idx].op;
          iss_src1             <= r_ent[w_pick_idx].src1.data;
          iss_src2             <= r_ent[w_pick_idx].src2.data;
          iss_dst_tag          <= r_ent[w_pick_idx].dst_tag;
          iss_dst_name         <= r_ent[w_pick_idx].dst_name;
          r_valid[w_pick_idx]  <= 1'b0;
        end else begin
          iss_valid <= DISABLE;
        end
      end
      if (w_disp_we) begin
        r_valid[w_free_idx] <= 1'b1;
      end
    end
  end

endmodule
